// File: rtl/ddr_axi_master.sv
// Single-beat 64-bit AXI master behind a level-request DDR port, one transaction at a time.
// Define DDR_AXI_ADDR_CHECK_EN to reject addresses outside 0x0010_0000-0x3FFF_FFFF locally.
module ddr_axi_master #(
  parameter logic [5:0] AXI_ID = 6'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ddr_req,
  input  logic [31:0] ddr_addr,
  input  logic [63:0] ddr_wdata,
  input  logic [7:0]  ddr_wstrb,
  output logic [63:0] ddr_rdata,
  output logic        ddr_ready,
  output logic        ddr_busy,
  output logic        ddr_err,
  output logic [5:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [5:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} state_t;

  state_t      state;
  logic [31:0] addr_r;
  logic [63:0] wdata_r;
  logic [7:0]  wstrb_r;
  logic        addr_bad;
  logic        unused_ok;

  always_comb begin
    addr_bad = 1'b0;
`ifdef DDR_AXI_ADDR_CHECK_EN
    addr_bad = (ddr_addr < 32'h0010_0000) || (ddr_addr > 32'h3FFF_FFFF);
`endif
  end

  assign awid    = AXI_ID;
  assign arid    = AXI_ID;
  assign awlen   = 4'd0;
  assign arlen   = 4'd0;
  assign awsize  = 3'd3;
  assign arsize  = 3'd3;
  assign awburst = 2'b01;
  assign arburst = 2'b01;
  assign wlast   = 1'b1;
  assign awaddr  = {addr_r[31:3], 3'b000};
  assign araddr  = {addr_r[31:3], 3'b000};
  assign wdata   = wdata_r;
  assign wstrb   = wstrb_r;

  // Single-beat bursts make rlast redundant; the byte offset never reaches the bus.
  assign unused_ok = ^{rlast, addr_r[2:0]};

  // Request payload is captured only at acceptance, so it stays stable under AXI back-pressure.
  always_ff @(posedge clk) begin
    if (state == IDLE && ddr_req) begin
      addr_r  <= ddr_addr;
      wdata_r <= ddr_wdata;
      wstrb_r <= ddr_wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      arvalid   <= 1'b0;
      bready    <= 1'b0;
      rready    <= 1'b0;
      ddr_ready <= 1'b0;
      ddr_busy  <= 1'b0;
      ddr_err   <= 1'b0;
      ddr_rdata <= 64'd0;
    end else begin
      ddr_ready <= 1'b0;
      ddr_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (ddr_req) begin
            ddr_busy <= 1'b1;
            if (addr_bad) begin
              state     <= DONE;
              ddr_ready <= 1'b1;
              ddr_err   <= 1'b1;
            end else if (ddr_wstrb != 8'h00) begin
              state   <= WADDR;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
            end else begin
              state   <= RADDR;
              arvalid <= 1'b1;
            end
          end
        end
        WADDR: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready) wvalid <= 1'b0;
          // Each channel is done once its valid has dropped or is handshaking now.
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            state  <= WRESP;
            bready <= 1'b1;
          end
        end
        WRESP: begin
          if (bvalid) begin
            state     <= DONE;
            bready    <= 1'b0;
            ddr_ready <= 1'b1;
            ddr_err   <= (bresp != 2'b00);
          end
        end
        RADDR: begin
          if (arready) begin
            state   <= RDATA;
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        end
        RDATA: begin
          if (rvalid) begin
            state     <= DONE;
            rready    <= 1'b0;
            ddr_rdata <= rdata;
            ddr_ready <= 1'b1;
            ddr_err   <= (rresp != 2'b00);
          end
        end
        DONE: begin
          state    <= IDLE;
          ddr_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
